note_lane_renderer: RTL

Per-lane renderer for falling note sprites. It keeps the positions of up to NOTES active notes in one fret lane and advances them once per video frame. For each VGA pixel it generates the 13-bit sprite-ROM read address and turns the ROM's 24-bit colour into a keyed pixel (pixel_on/pixel_color) for the colour mapper. It sits directly upstream of the orange 64×64 sprite ROM and consumes that ROM's registered output.

---
 rtl/note_pkg.sv | 12 +
 rtl/note_slot.sv | 54 +++++
 rtl/note_lane_renderer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/note_pkg.sv
// Shared constants and the per-slot state record for the note lane renderer.
package note_pkg;
    localparam int          SPRITE_W  = 64;
    localparam int          SPRITE_AW = 13;
    localparam int          SCREEN_H  = 480;
    localparam logic [23:0] KEY_COLOR = 24'hFF00FF;

    typedef struct packed {
        logic       active;
        logic [9:0] y_top;
    } slot_t;
endpackage

// File: rtl/note_slot.sv
// One falling-note slot: position register, per-frame move/retire, spawn/clear,
// and the sprite-window hit test for the current pixel.
module note_slot
    import note_pkg::*;
#(
    parameter logic [9:0] LANE_X = 10'd400,
    parameter int         SPEED  = 2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic       load,
    input  logic       clear,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic       active,
    output logic [9:0] y_top,
    output logic       in_range,
    output logic [5:0] row,
    output logic [5:0] col
);
    logic [10:0] moved;
    logic [10:0] dx;
    logic [10:0] dy;

    // Eleven bits so the sum cannot wrap before the bottom-of-screen compare.
    assign moved = {1'b0, y_top} + 11'(SPEED);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            active <= 1'b0;
            y_top  <= '0;
        end else if (clear) begin
            active <= 1'b0;
        end else if (load) begin
            active <= 1'b1;
            y_top  <= '0;
        end else if (frame_tick && active) begin
            y_top <= moved[9:0];
            if (moved >= 11'(SCREEN_H)) begin
                active <= 1'b0;
            end
        end
    end

    // Bit 10 is the borrow: a pixel left of / above the sprite is rejected.
    assign dx = {1'b0, DrawX} - {1'b0, LANE_X};
    assign dy = {1'b0, DrawY} - {1'b0, y_top};

    assign in_range = active && !dx[10] && !dy[10]
                      && (dx[9:0] < 10'(SPRITE_W)) && (dy[9:0] < 10'(SPRITE_W));
    assign row = dy[5:0];
    assign col = dx[5:0];
endmodule

// File: rtl/note_lane_renderer.sv
// Lane renderer: owns NOTES note slots, arbitrates spawn/hit/draw among them,
// and turns the sprite ROM's registered colour into a keyed pixel two cycles on.
module note_lane_renderer
    import note_pkg::*;
#(
    parameter int         NOTES  = 4,
    parameter logic [9:0] LANE_X = 10'd400,
    parameter int         SPEED  = 2,
    parameter logic [9:0] HIT_Y  = 10'd400
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             frame_tick,
    input  logic             spawn,
    input  logic             hit,
    input  logic [9:0]       DrawX,
    input  logic [9:0]       DrawY,
    input  logic [23:0]      rom_data,
    output logic [12:0]      read_address,
    output logic             pixel_on,
    output logic [23:0]      pixel_color,
    output logic             spawn_drop,
    output logic             hit_ok,
    output logic             hit_miss,
    output logic [NOTES-1:0] active_mask
);
    slot_t            slots [NOTES];
    logic [NOTES-1:0] slot_active;
    logic [9:0]       slot_y [NOTES];
    logic [NOTES-1:0] in_range;
    logic [5:0]       rows [NOTES];
    logic [5:0]       cols [NOTES];
    logic [NOTES-1:0] load_vec;
    logic [NOTES-1:0] hit_vec;
    logic [NOTES-1:0] clear_vec;
    logic             free_found;
    logic             hit_found;
    logic [9:0]       best_y;
    logic             sel_found;
    logic [5:0]       sel_row;
    logic [5:0]       sel_col;
    logic             in_range_d;
    logic             opaque;

    function automatic logic in_window(input logic [9:0] y);
        return (y >= HIT_Y) && ({1'b0, y} <= ({1'b0, HIT_Y} + 11'd31));
    endfunction

    for (genvar i = 0; i < NOTES; i++) begin : g_slot
        note_slot #(.LANE_X(LANE_X), .SPEED(SPEED)) u_slot (
            .Clk        (Clk),
            .Reset_n    (Reset_n),
            .frame_tick (frame_tick),
            .load       (load_vec[i]),
            .clear      (clear_vec[i]),
            .DrawX      (DrawX),
            .DrawY      (DrawY),
            .active     (slot_active[i]),
            .y_top      (slot_y[i]),
            .in_range   (in_range[i]),
            .row        (rows[i]),
            .col        (cols[i])
        );
        assign slots[i] = '{active: slot_active[i], y_top: slot_y[i]};
    end

    assign active_mask = slot_active;

    // Free-slot search uses pre-hit occupancy, so a slot freed this cycle stays empty.
    always_comb begin
        load_vec   = '0;
        free_found = 1'b0;
        for (int i = 0; i < NOTES; i++) begin
            if (!free_found && !slots[i].active) begin
                load_vec[i] = spawn;
                free_found  = 1'b1;
            end
        end
    end

    // Deepest note in the window wins; strict '>' keeps ties on the lowest index.
    always_comb begin
        hit_vec   = '0;
        hit_found = 1'b0;
        best_y    = '0;
        for (int i = 0; i < NOTES; i++) begin
            if (slots[i].active && in_window(slots[i].y_top)
                && (!hit_found || slots[i].y_top > best_y)) begin
                hit_vec    = '0;
                hit_vec[i] = 1'b1;
                best_y     = slots[i].y_top;
                hit_found  = 1'b1;
            end
        end
    end

    assign clear_vec = hit ? hit_vec : '0;

    always_comb begin
        sel_found = 1'b0;
        sel_row   = '0;
        sel_col   = '0;
        for (int i = 0; i < NOTES; i++) begin
            if (!sel_found && in_range[i]) begin
                sel_found = 1'b1;
                sel_row   = rows[i];
                sel_col   = cols[i];
            end
        end
    end

    assign read_address = sel_found ? {1'b0, sel_row, sel_col} : '0;
    assign opaque       = in_range_d && (rom_data != KEY_COLOR);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            in_range_d  <= 1'b0;
            pixel_on    <= 1'b0;
            pixel_color <= '0;
            spawn_drop  <= 1'b0;
            hit_ok      <= 1'b0;
            hit_miss    <= 1'b0;
        end else begin
            in_range_d  <= sel_found;
            pixel_on    <= opaque;
            pixel_color <= opaque ? rom_data : '0;
            spawn_drop  <= spawn && !free_found;
            hit_ok      <= hit && hit_found;
            hit_miss    <= hit && !hit_found;
        end
    end
endmodule
